// File: rtl/stack_alu.sv
// stack_alu: Forth execution stage on top of the data-stack block.
// Optional FAST_MUL_EN selects a single-cycle multiplier.
module stack_alu #(
  parameter int WIDTH     = 16,
  parameter int DEPTH_MAX = 255
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             OpValid,
  output logic             OpReady,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] Lit,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] N,
  output logic             TWrite,
  output logic             NWrite,
  output logic [WIDTH-1:0] WData,
  output logic [7:0]       Offset,
  output logic             Done,
  output logic             Underflow,
  output logic             Overflow,
  output logic             DivZero,
  output logic             IllegalOp,
  output logic [7:0]       Depth
);

  typedef enum logic [2:0] {
    IDLE, WB, SWAP2, MUL_RUN, DIV_RUN, ERR
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_DUP  = 4'd7;
  localparam logic [3:0] OP_DROP = 4'd8;
  localparam logic [3:0] OP_SWAP = 4'd9;
  localparam logic [3:0] OP_OVER = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_MOD  = 4'd13;
  localparam logic [3:0] OP_LIT  = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  localparam logic [7:0] DMAX = 8'(DEPTH_MAX);
  localparam logic [7:0] POP  = 8'hFF;
  localparam logic [7:0] PUSH = 8'h01;

`ifdef FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] acc;
  logic [3:0]       cnt;

  logic [1:0]       need;
  logic [7:0]       net;
  logic             tw;
  logic             dz;
  logic [WIDTH-1:0] res;
  logic             accept;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_rs;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  assign accept = OpValid && OpReady;

  // Operand count, net pointer move and single-cycle result per opcode
  always_comb begin
    need = 2'd0;
    net  = 8'h00;
    tw   = 1'b0;
    res  = '0;
    case (Op)
      OP_ADD:  begin need = 2'd2; net = POP; tw = 1'b1; res = N + T; end
      OP_SUB:  begin need = 2'd2; net = POP; tw = 1'b1; res = N - T; end
      OP_AND:  begin need = 2'd2; net = POP; tw = 1'b1; res = N & T; end
      OP_OR:   begin need = 2'd2; net = POP; tw = 1'b1; res = N | T; end
      OP_XOR:  begin need = 2'd2; net = POP; tw = 1'b1; res = N ^ T; end
      OP_NOT:  begin need = 2'd1; tw = 1'b1; res = ~T; end
      OP_DUP:  begin need = 2'd1; net = PUSH; tw = 1'b1; res = T; end
      OP_DROP: begin need = 2'd1; net = POP; end
      OP_SWAP: begin need = 2'd2; tw = 1'b1; res = N; end
      OP_OVER: begin need = 2'd2; net = PUSH; tw = 1'b1; res = N; end
      OP_MUL:  begin need = 2'd2; net = POP; tw = 1'b1; res = N * T; end
      OP_DIV:  begin need = 2'd2; net = POP; tw = 1'b1; res = '1; end
      OP_MOD:  begin need = 2'd2; net = POP; tw = 1'b1; res = N; end
      OP_LIT:  begin net = PUSH; tw = 1'b1; res = Lit; end
      default: ;
    endcase
  end

  assign dz = (Op == OP_DIV || Op == OP_MOD) && (T == '0);

  // One shift-add step and one restoring-divide step
  always_comb begin
    mul_acc  = acc + (t_q[0] ? n_q : '0);
    div_rs   = {acc, n_q[WIDTH-1]};
    div_diff = div_rs - {1'b0, t_q};
    if (!div_diff[WIDTH]) begin
      rem_n = div_diff[WIDTH-1:0];
      quo_n = {n_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = div_rs[WIDTH-1:0];
      quo_n = {n_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered strobes, pulses and depth tracking
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      t_q       <= '0;
      n_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      OpReady   <= 1'b0;
      TWrite    <= 1'b0;
      NWrite    <= 1'b0;
      WData     <= '0;
      Offset    <= '0;
      Done      <= 1'b0;
      Underflow <= 1'b0;
      Overflow  <= 1'b0;
      DivZero   <= 1'b0;
      IllegalOp <= 1'b0;
      Depth     <= '0;
    end else begin
      OpReady   <= 1'b0;
      TWrite    <= 1'b0;
      NWrite    <= 1'b0;
      Offset    <= '0;
      Done      <= 1'b0;
      Underflow <= 1'b0;
      Overflow  <= 1'b0;
      DivZero   <= 1'b0;
      IllegalOp <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= Op;
            t_q  <= T;
            n_q  <= N;
            acc  <= '0;
            cnt  <= '0;
            if (Op == OP_ILL) begin
              state     <= ERR;
              IllegalOp <= 1'b1;
              Done      <= 1'b1;
            end else if (Depth < {6'd0, need}) begin
              state     <= ERR;
              Underflow <= 1'b1;
              Done      <= 1'b1;
            end else if (Depth == DMAX && net == PUSH) begin
              state    <= ERR;
              Overflow <= 1'b1;
              Done     <= 1'b1;
            end else if (Op == OP_MUL && !FastMul) begin
              state <= MUL_RUN;
            end else if ((Op == OP_DIV || Op == OP_MOD) && !dz) begin
              state <= DIV_RUN;
            end else if (Op == OP_SWAP) begin
              state  <= WB;
              TWrite <= 1'b1;
              WData  <= N;
            end else begin
              state   <= WB;
              TWrite  <= tw;
              WData   <= res;
              Offset  <= net;
              Done    <= 1'b1;
              DivZero <= dz;
              Depth   <= Depth + net;
            end
          end else begin
            OpReady <= 1'b1;
          end
        end
        WB: begin
          if (op_q == OP_SWAP) begin
            state  <= SWAP2;
            NWrite <= 1'b1;
            WData  <= t_q;
            Done   <= 1'b1;
          end else begin
            state   <= IDLE;
            OpReady <= 1'b1;
          end
        end
        MUL_RUN: begin
          acc <= mul_acc;
          n_q <= n_q << 1;
          t_q <= t_q >> 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state  <= WB;
            TWrite <= 1'b1;
            WData  <= mul_acc;
            Offset <= POP;
            Done   <= 1'b1;
            Depth  <= Depth + POP;
          end
        end
        DIV_RUN: begin
          acc <= rem_n;
          n_q <= quo_n;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state  <= WB;
            TWrite <= 1'b1;
            WData  <= (op_q == OP_DIV) ? quo_n : rem_n;
            Offset <= POP;
            Done   <= 1'b1;
            Depth  <= Depth + POP;
          end
        end
        default: begin
          state   <= IDLE;
          OpReady <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: directed scenarios for the stack_alu execution stage.
// Outputs are sampled on the falling clock edge.
module tb_stack_alu;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        OpValid;
  logic        OpReady;
  logic [3:0]  Op;
  logic [15:0] Lit;
  logic [15:0] T;
  logic [15:0] N;
  logic        TWrite;
  logic        NWrite;
  logic [15:0] WData;
  logic [7:0]  Offset;
  logic        Done;
  logic        Underflow;
  logic        Overflow;
  logic        DivZero;
  logic        IllegalOp;
  logic [7:0]  Depth;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 17;
`endif

  stack_alu #(.WIDTH(16), .DEPTH_MAX(255)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .OpValid(OpValid), .OpReady(OpReady),
    .Op(Op), .Lit(Lit), .T(T), .N(N),
    .TWrite(TWrite), .NWrite(NWrite),
    .WData(WData), .Offset(Offset),
    .Done(Done), .Underflow(Underflow),
    .Overflow(Overflow), .DivZero(DivZero),
    .IllegalOp(IllegalOp), .Depth(Depth)
  );

  always #5 Clk = ~Clk;

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  // Present one op; returns at the falling edge of cycle k+1
  task automatic issue(input logic [3:0] op, input logic [15:0] lit,
                       input logic [15:0] t, input logic [15:0] n);
    int w;
    w = 0;
    while (OpReady !== 1'b1 && w < 64) begin
      @(negedge Clk);
      w++;
    end
    if (OpReady !== 1'b1) begin
      n_assert++; n_fail++;
      $display("FAIL issue_ready got=%b want=1", OpReady);
    end
    Op = op; Lit = lit; T = t; N = n; OpValid = 1'b1;
    @(negedge Clk);
    OpValid = 1'b0;
    T = 16'h5A5A;
    N = 16'hA5A5;
  endtask

  // Wait for Done; lat counts cycles after accept
  task automatic wait_done(output int lat, output bit rdy_seen);
    lat = 1;
    rdy_seen = 1'b0;
    while (Done !== 1'b1 && lat < 40) begin
      if (OpReady === 1'b1) rdy_seen = 1'b1;
      @(negedge Clk);
      lat++;
    end
    if (OpReady === 1'b1) rdy_seen = 1'b1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    #1;
    n_assert++;
    if ({OpReady, TWrite, NWrite, Done, Offset, WData, Depth} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b tw=%b nw=%b done=%b off=%h wd=%h dep=%0d want all 0",
               OpReady, TWrite, NWrite, Done, Offset, WData, Depth);
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    n_assert++;
    if (OpReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b want=1", OpReady);
    end
  endtask

  task automatic test_lit_add();
    do_reset();
    issue(4'd14, 16'h0005, 16'h0000, 16'h0000);
    n_assert++;
    if ({TWrite, NWrite, Offset, WData, Done, OpReady} !== {2'b10, 8'h01, 16'h0005, 2'b10}) begin
      n_fail++;
      $display("FAIL lit5 got tw=%b nw=%b off=%h wd=%h done=%b rdy=%b want 1 0 01 0005 1 0",
               TWrite, NWrite, Offset, WData, Done, OpReady);
    end
    @(negedge Clk);
    n_assert++;
    if ({TWrite, Done, Offset, OpReady} !== {2'b00, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL lit_k2 got tw=%b done=%b off=%h rdy=%b want 0 0 00 1",
               TWrite, Done, Offset, OpReady);
    end
    issue(4'd14, 16'h0003, 16'h0005, 16'h0000);
    issue(4'd1, 16'h0000, 16'h0003, 16'h0005);
    n_assert++;
    if ({TWrite, Offset, WData, Depth} !== {1'b1, 8'hFF, 16'h0008, 8'd1}) begin
      n_fail++;
      $display("FAIL add got tw=%b off=%h wd=%h dep=%0d want 1 ff 0008 1",
               TWrite, Offset, WData, Depth);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [10] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                              4'd7, 4'd10, 4'd1, 4'd8, 4'd0};
    logic [15:0] nv  [10] = '{16'h0003, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h0000,
                              16'h0000, 16'h1111, 16'hFFFF, 16'h0000, 16'h0000};
    logic [15:0] tv  [10] = '{16'h0005, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h00FF,
                              16'hBEEF, 16'h2222, 16'h0002, 16'h0001, 16'h0001};
    logic [15:0] ew  [10] = '{16'hFFFE, 16'h3030, 16'hFCFC, 16'hCCCC, 16'hFF00,
                              16'hBEEF, 16'h1111, 16'h0001, 16'h0000, 16'h0000};
    logic        etw [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic [7:0]  eof [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                              8'h01, 8'h01, 8'hFF, 8'hFF, 8'h00};
    logic [7:0]  edp [10] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2,
                              8'd3, 8'd3, 8'd1, 8'd1, 8'd2};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      issue(4'd14, 16'h0001, 16'h0000, 16'h0000);
      issue(4'd14, 16'h0002, 16'h0001, 16'h0000);
      issue(ops[i], 16'h0000, tv[i], nv[i]);
      n_assert++;
      if (TWrite !== etw[i] || Offset !== eof[i] || Depth !== edp[i] ||
          Done !== 1'b1 || NWrite !== 1'b0 ||
          (etw[i] && WData !== ew[i])) begin
        n_fail++;
        $display("FAIL alu_op%0d got tw=%b off=%h wd=%h dep=%0d done=%b want tw=%b off=%h wd=%h dep=%0d done=1",
                 ops[i], TWrite, Offset, WData, Depth, Done, etw[i], eof[i], ew[i], edp[i]);
      end
    end
  endtask

  task automatic test_swap();
    do_reset();
    issue(4'd14, 16'hABCD, 16'h0000, 16'h0000);
    issue(4'd14, 16'h1234, 16'hABCD, 16'h0000);
    issue(4'd9, 16'h0000, 16'h1234, 16'hABCD);
    n_assert++;
    if ({TWrite, NWrite, WData, Offset, Done} !== {2'b10, 16'hABCD, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL swap_k1 got tw=%b nw=%b wd=%h off=%h done=%b want 1 0 abcd 00 0",
               TWrite, NWrite, WData, Offset, Done);
    end
    @(negedge Clk);
    n_assert++;
    if ({TWrite, NWrite, WData, Offset, Done, Depth} !== {2'b01, 16'h1234, 8'h00, 1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL swap_k2 got tw=%b nw=%b wd=%h off=%h done=%b dep=%0d want 0 1 1234 00 1 2",
               TWrite, NWrite, WData, Offset, Done, Depth);
    end
  endtask

  task automatic test_mul();
    int lat;
    bit rdy;
    logic [15:0] nv [2] = '{16'h0100, 16'h1234};
    logic [15:0] tv [2] = '{16'h0003, 16'h5678};
    logic [15:0] ev [2] = '{16'h0300, 16'h0060};
    do_reset();
    issue(4'd14, 16'h0001, 16'h0000, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      issue(4'd14, 16'h0002, 16'h0000, 16'h0000);
      issue(4'd11, 16'h0000, tv[i], nv[i]);
      wait_done(lat, rdy);
      n_assert++;
      if (lat != MUL_LAT || rdy || WData !== ev[i] || TWrite !== 1'b1 ||
          Offset !== 8'hFF || Depth !== 8'd1) begin
        n_fail++;
        $display("FAIL mul%0d got lat=%0d rdy=%b wd=%h tw=%b off=%h dep=%0d want lat=%0d rdy=0 wd=%h tw=1 off=ff dep=1",
                 i, lat, rdy, WData, TWrite, Offset, Depth, MUL_LAT, ev[i]);
      end
    end
  endtask

  task automatic test_div();
    int lat;
    bit rdy;
    logic [3:0]  ops [6] = '{4'd12, 4'd13, 4'd12, 4'd13, 4'd12, 4'd13};
    logic [15:0] nv  [6] = '{16'd100, 16'd100, 16'hFFFF, 16'hFFFF, 16'h0007, 16'h0007};
    logic [15:0] tv  [6] = '{16'd7, 16'd7, 16'h00FF, 16'h00FF, 16'h0000, 16'h0000};
    logic [15:0] ev  [6] = '{16'h000E, 16'h0002, 16'h0101, 16'h0000, 16'hFFFF, 16'h0007};
    int          el  [6] = '{17, 17, 17, 17, 1, 1};
    logic        edz [6] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    issue(4'd14, 16'h0001, 16'h0000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      issue(4'd14, 16'h0002, 16'h0000, 16'h0000);
      issue(ops[i], 16'h0000, tv[i], nv[i]);
      wait_done(lat, rdy);
      n_assert++;
      if (lat != el[i] || rdy || WData !== ev[i] || DivZero !== edz[i] ||
          TWrite !== 1'b1 || Offset !== 8'hFF || Depth !== 8'd1) begin
        n_fail++;
        $display("FAIL div%0d got lat=%0d rdy=%b wd=%h dz=%b tw=%b off=%h dep=%0d want lat=%0d rdy=0 wd=%h dz=%b tw=1 off=ff dep=1",
                 i, lat, rdy, WData, DivZero, TWrite, Offset, Depth, el[i], ev[i], edz[i]);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    issue(4'd8, 16'h0000, 16'h0000, 16'h0000);
    n_assert++;
    if ({Underflow, Done, TWrite, NWrite, Offset, Depth} !== {4'b1100, 8'h00, 8'd0}) begin
      n_fail++;
      $display("FAIL uflow_drop got uf=%b done=%b tw=%b nw=%b off=%h dep=%0d want 1 1 0 0 00 0",
               Underflow, Done, TWrite, NWrite, Offset, Depth);
    end
    issue(4'd14, 16'h0009, 16'h0000, 16'h0000);
    issue(4'd1, 16'h0000, 16'h0009, 16'h0000);
    n_assert++;
    if ({Underflow, Done, TWrite, Depth} !== {3'b110, 8'd1}) begin
      n_fail++;
      $display("FAIL uflow_add got uf=%b done=%b tw=%b dep=%0d want 1 1 0 1",
               Underflow, Done, TWrite, Depth);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 255; i++)
      issue(4'd14, 16'(i), 16'h0000, 16'h0000);
    n_assert++;
    if (Depth !== 8'd255) begin
      n_fail++;
      $display("FAIL oflow_fill got dep=%0d want 255", Depth);
    end
    issue(4'd7, 16'h0000, 16'h00FE, 16'h00FD);
    n_assert++;
    if ({Overflow, Done, TWrite, Offset, Depth} !== {3'b110, 8'h00, 8'd255}) begin
      n_fail++;
      $display("FAIL oflow_dup got of=%b done=%b tw=%b off=%h dep=%0d want 1 1 0 00 255",
               Overflow, Done, TWrite, Offset, Depth);
    end
    @(negedge Clk);
    n_assert++;
    if (Overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL oflow_pulse got of=%b want 0", Overflow);
    end
    issue(4'd8, 16'h0000, 16'h00FE, 16'h00FD);
    n_assert++;
    if ({Overflow, Offset, Depth} !== {1'b0, 8'hFF, 8'd254}) begin
      n_fail++;
      $display("FAIL oflow_drop got of=%b off=%h dep=%0d want 0 ff 254",
               Overflow, Offset, Depth);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    issue(4'd15, 16'h0000, 16'h0000, 16'h0000);
    n_assert++;
    if ({IllegalOp, Done, TWrite, NWrite, Offset, Depth} !== {4'b1100, 8'h00, 8'd0}) begin
      n_fail++;
      $display("FAIL illegal got ill=%b done=%b tw=%b nw=%b off=%h dep=%0d want 1 1 0 0 00 0",
               IllegalOp, Done, TWrite, NWrite, Offset, Depth);
    end
  endtask

  task automatic test_reset_mid_div();
    int seen;
    do_reset();
    issue(4'd14, 16'h0064, 16'h0000, 16'h0000);
    issue(4'd14, 16'h0007, 16'h0064, 16'h0000);
    issue(4'd12, 16'h0000, 16'h0007, 16'h0064);
    repeat (4) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    n_assert++;
    if ({TWrite, NWrite, Done, DivZero, Offset, WData, Depth, OpReady} !== '0) begin
      n_fail++;
      $display("FAIL abort_state got tw=%b nw=%b done=%b off=%h wd=%h dep=%0d rdy=%b want all 0",
               TWrite, NWrite, Done, Offset, WData, Depth, OpReady);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Done === 1'b1 || TWrite === 1'b1 || NWrite === 1'b1) seen++;
    end
    n_assert++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_quiet got %0d active cycles want 0", seen);
    end
    issue(4'd14, 16'h0001, 16'h0000, 16'h0000);
    n_assert++;
    if ({TWrite, Done, WData, Offset, Depth} !== {2'b11, 16'h0001, 8'h01, 8'd1}) begin
      n_fail++;
      $display("FAIL abort_lit got tw=%b done=%b wd=%h off=%h dep=%0d want 1 1 0001 01 1",
               TWrite, Done, WData, Offset, Depth);
    end
  endtask

  initial begin
    OpValid = 1'b0;
    Op = 4'd0;
    Lit = '0;
    T = '0;
    N = '0;
    test_reset();
    test_lit_add();
    test_alu_ops();
    test_swap();
    test_mul();
    test_div();
    test_underflow();
    test_overflow();
    test_illegal();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
